// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_if
// Purpose  : Start/done handshake and operand/result bundle for
//            serial_subtractor.
// Signals  : start, A, B, Bin   requester -> subtractor
//            ready, done        subtractor -> requester (handshake)
//            Diff, Bout,
//            Overflow           subtractor -> requester (results)
// Modports : master (requester side), slave (subtractor side)
// Revision : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             Overflow;

  modport master (
    output start, A, B, Bin,
    input  ready, done, Diff, Bout, Overflow
  );

  modport slave (
    input  start, A, B, Bin,
    output ready, done, Diff, Bout, Overflow
  );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Digit-serial two's-complement subtractor.
//            Diff = A - B - Bin, one DIGIT-wide slice per clock, least
//            significant digit first, computed as A + ~B + ~Bin.
//            Reports unsigned borrow-out and signed overflow.
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous active-high reset
//            bus  - serial_subtractor_if.slave (start/ready/done handshake,
//                   operands A, B, Bin, results Diff, Bout, Overflow)
// Params   : WIDTH - operand width, multiple of DIGIT
//            DIGIT - bits processed per clock
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  wire               clk,
  input  wire               rst,
  serial_subtractor_if.slave bus
);

  localparam int c_ndig = WIDTH / DIGIT;
  localparam int c_cw   = (c_ndig > 1) ? $clog2(c_ndig) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(c_ndig - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [c_cw-1:0]  r_cnt;
  logic [WIDTH-1:0] r_a;      // minuend, shifted right each digit
  logic [WIDTH-1:0] r_nb;     // inverted subtrahend, shifted right each digit
  logic             r_carry;  // inter-digit carry
  logic [WIDTH-1:0] r_diff;   // doubles as the result shift register
  logic             r_bout;
  logic             r_ovf;
  logic             r_ready;
  logic             r_done;

  logic [DIGIT:0]   w_sum;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_diff_next;

  // One digit of A + ~B + carry; bit DIGIT is the digit carry-out.
  assign w_sum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_nb[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, r_carry};

  // Carry into the digit's top bit recovered from its sum bit: s = a ^ b ^ c.
  assign w_cmsb = w_sum[DIGIT-1] ^ r_a[DIGIT-1] ^ r_nb[DIGIT-1];

  // New sum digit enters at the top so after NDIG digits it sits aligned.
  generate
    if (WIDTH > DIGIT) begin : g_diff_shift
      assign w_diff_next = {w_sum[DIGIT-1:0], r_diff[WIDTH-1:DIGIT]};
    end else begin : g_diff_single
      assign w_diff_next = w_sum[DIGIT-1:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_nb    <= '0;
      r_carry <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.A;
            r_nb    <= ~bus.B;
            r_carry <= ~bus.Bin;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          r_a     <= r_a >> DIGIT;
          r_nb    <= r_nb >> DIGIT;
          r_carry <= w_sum[DIGIT];
          r_diff  <= w_diff_next;
          r_cnt   <= r_cnt + c_cw'(1);
          if (r_cnt == c_last) begin
            // A set carry-out means no borrow.
            r_bout  <= ~w_sum[DIGIT];
            r_ovf   <= w_cmsb ^ w_sum[DIGIT];
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready    = r_ready;
  assign bus.done     = r_done;
  assign bus.Diff     = r_diff;
  assign bus.Bout     = r_bout;
  assign bus.Overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Self-checking bench for serial_subtractor: directed vectors,
//            handshake timing, ignored start, back-to-back start, mid-run
//            reset, and a random sweep against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int c_width = 32;
  localparam int c_digit = 4;
  localparam int c_ndig  = c_width / c_digit;

  logic clk;
  logic rst;
  int   r_checks;
  int   r_errors;

  serial_subtractor_if #(.WIDTH(c_width)) bus ();

  serial_subtractor #(
    .WIDTH(c_width),
    .DIGIT(c_digit)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    r_checks++;
    if (obs !== exp) begin
      r_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for a done pulse; returns edges elapsed. Sampling is #1 after edges.
  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!bus.done && edges < 40);
    if (!bus.done) check("done_timeout", 64'd0, 64'd1);
  endtask

  // Accept an operation (waiting for ready) and wait for its done pulse.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic bin, output int edges);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    bus.A = a; bus.B = b; bus.Bin = bin; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("ready_low_after_accept", 64'(bus.ready), 64'd0);
    wait_done(edges);
  endtask

  // Independent arithmetic model.
  task automatic check_model(input string tag, input logic [31:0] a,
                             input logic [31:0] b, input logic bin);
    logic [31:0] e_diff;
    logic        e_bout;
    logic        e_ovf;
    longint      sd;
    e_diff = a - b - {31'd0, bin};
    e_bout = ({1'b0, a} < ({1'b0, b} + {32'd0, bin}));
    sd     = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
    e_ovf  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    check({tag, ".diff"}, 64'(bus.Diff), 64'(e_diff));
    check({tag, ".bout"}, 64'(bus.Bout), 64'(e_bout));
    check({tag, ".ovf"},  64'(bus.Overflow), 64'(e_ovf));
  endtask

  task automatic check_direct(input string tag, input logic [31:0] d,
                              input logic bo, input logic ov);
    check({tag, ".diff"}, 64'(bus.Diff), 64'(d));
    check({tag, ".bout"}, 64'(bus.Bout), 64'(bo));
    check({tag, ".ovf"},  64'(bus.Overflow), 64'(ov));
  endtask

  initial begin
    int e;
    int dn;
    logic [31:0] ra, rb;
    logic        rbin;

    r_checks = 0;
    r_errors = 0;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.A = 32'd5; bus.B = 32'd3; bus.Bin = 1'b0;

    // Reset state while reset held (start already high).
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_done",  64'(bus.done),  64'd0);
    check_direct("rst", 32'd0, 1'b0, 1'b0);

    // Release reset with start high: first clean edge accepts.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("rst_release_accept", 64'(bus.ready), 64'd0);
    wait_done(e);
    // done visible NDIG edges after the accepting edge (9th cycle counting it)
    check("latency_edges", 64'(e), 64'(c_ndig));
    check_direct("5-3", 32'h0000_0002, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("done_one_cycle", 64'(bus.done), 64'd0);
    check("ready_back", 64'(bus.ready), 64'd1);
    check_direct("hold", 32'h0000_0002, 1'b0, 1'b0);

    // Directed vectors with hand-computed results.
    run_op(32'd3, 32'd5, 1'b0, e);
    check_direct("3-5", 32'hFFFF_FFFE, 1'b1, 1'b0);
    run_op(32'h8000_0000, 32'd1, 1'b0, e);
    check_direct("min-1", 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, e);
    check_direct("max-m1", 32'h8000_0000, 1'b1, 1'b1);
    run_op(32'd10, 32'd3, 1'b1, e);
    check_direct("10-3-1", 32'd6, 1'b0, 1'b0);
    run_op(32'd0, 32'd0, 1'b1, e);
    check_direct("0-0-1", 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op(32'h1234_5678, 32'h1234_5678, 1'b1, e);
    check_direct("eq_bin", 32'hFFFF_FFFF, 1'b1, 1'b0);

    // start during RUN is ignored; exactly one done pulse.
    @(negedge clk);
    while (!bus.ready) @(negedge clk);
    bus.A = 32'd1000; bus.B = 32'd1; bus.Bin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.A = 32'd7; bus.B = 32'd9; bus.Bin = 1'b1; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dn = 0;
    for (int i = 0; i < 14; i++) begin
      if (bus.done) begin
        dn++;
        check_direct("ignored_start", 32'd999, 1'b0, 1'b0);
      end
      @(posedge clk);
      #1;
    end
    check("single_done", 64'(dn), 64'd1);

    // start held high: back-to-back acceptance every NDIG+2 edges.
    @(negedge clk);
    bus.A = 32'd20; bus.B = 32'd5; bus.Bin = 1'b0; bus.start = 1'b1;
    wait_done(e);
    check_direct("cont1", 32'd15, 1'b0, 1'b0);
    wait_done(e);
    bus.start = 1'b0;
    check("cont_period", 64'(e), 64'(c_ndig + 2));
    check_direct("cont2", 32'd15, 1'b0, 1'b0);
    repeat (3) @(posedge clk);

    // Reset during RUN abandons the operation.
    @(negedge clk);
    while (!bus.ready) @(negedge clk);
    bus.A = 32'd50; bus.B = 32'd8; bus.Bin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", 64'(bus.ready), 64'd1);
    check("midrst_done",  64'(bus.done),  64'd0);
    check_direct("midrst", 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dn++;
    end
    check("midrst_no_done", 64'(dn), 64'd0);
    run_op(32'd100, 32'd1, 1'b0, e);
    check_direct("100-1", 32'd99, 1'b0, 1'b0);

    // Random sweep against the model.
    for (int i = 0; i < 1000; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rbin = 1'($urandom_range(1, 0));
      if (i % 8 == 0) rb = ra;
      run_op(ra, rb, rbin, e);
      check_model("rand", ra, rb, rbin);
    end

    $display("Simulation finished: %0d checks, %0d errors", r_checks, r_errors);
    $finish;
  end

endmodule
`default_nettype wire
